mem_access: RTL

- Data-memory access stage between the EX/MEM pipeline register and the MEM/WB register.
- Loads and stores go through a req/ack data-memory port. Store data is lane-aligned with byte enables; load data is extracted and sign/zero-extended.
- Non-memory instructions pass straight through.
- Stalls the upstream pipeline while an access is outstanding. Presents bubbles downstream because the MEM/WB register has no enable.

---
 rtl/mem_pkg.sv | 32 +++
 rtl/mem_access_load_align.sv | 33 +++
 rtl/mem_access.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the data-memory access stage.
// Latency: n/a (types, constants and a size-decode helper only).
// Backpressure: n/a.
package mem_pkg;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'b00,
    MEM_HALF = 2'b01,
    MEM_WORD = 2'b10
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } mem_state_t;

  localparam logic [3:0] BE_NONE    = 4'b0000;
  localparam logic [3:0] BE_LO_HALF = 4'b0011;
  localparam logic [3:0] BE_HI_HALF = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

  // Raw 2-bit size field to enum; the reserved encoding 11 behaves as a word.
  function automatic mem_size_t to_size(input logic [1:0] sz);
    case (sz)
      2'b00:   to_size = MEM_BYTE;
      2'b01:   to_size = MEM_HALF;
      default: to_size = MEM_WORD;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_load_align.sv
// Load lane extraction and sign/zero extension (little-endian).
// Latency: 0 cycles, purely combinational.
// Backpressure: none.
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  mem_size_t   size,
  input  logic        is_unsigned,
  output logic [31:0] data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Select the addressed lane, then extend it to a full word.
  always_comb begin
    case (addr)
      2'd0:    byte_v = rdata[7:0];
      2'd1:    byte_v = rdata[15:8];
      2'd2:    byte_v = rdata[23:16];
      default: byte_v = rdata[31:24];
    endcase
    half_v = addr[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      MEM_BYTE: data = {{24{~is_unsigned & byte_v[7]}}, byte_v};
      MEM_HALF: data = {{16{~is_unsigned & half_v[15]}}, half_v};
      default:  data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Data-memory access stage: drives a req/ack data port for loads and stores, passes other ops through.
// Latency: 0 cycles for non-memory ops; 3 cycles minimum for loads/stores (IDLE, BUSY until ack, DONE).
// Backpressure: stall holds EX/MEM while an access is outstanding; bubbles go downstream meanwhile.
// Optional: define MEM_MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of forcing alignment.
module mem_access
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_in,
  input  logic [ADDR_W-1:0] alu_result,
  input  logic [DATA_W-1:0] store_data,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [1:0]        mem_size,
  input  logic              mem_unsigned,
  input  logic              mem_to_reg,
  input  logic              reg_write,
  input  logic              halted,
  input  logic [4:0]        rd_num,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  output logic [3:0]        dmem_be,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic [ADDR_W-1:0] alu_result_out,
  output logic [DATA_W-1:0] read_data,
  output logic              mem_to_reg_out,
  output logic              reg_write_out,
  output logic              halted_out,
  output logic [4:0]        rd_num_out,
  output logic              stall,
  output logic              misaligned
);

  mem_state_t        state_q, state_d;
  logic              latch;
  logic              req_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, ld_data;
  logic [3:0]        be_q, be_d;
  mem_size_t         size_q, size_in;
  logic              st_q, uns_q, m2r_q, rw_q, halt_q;
  logic [4:0]        rd_q;
  logic              mem_op, mis_in;

  assign mem_op  = mem_read | mem_write;
  assign size_in = to_size(mem_size);

`ifdef MEM_MISALIGN_TRAP_EN
  assign mis_in = mem_op &
                  (((size_in == MEM_HALF) && alu_result[0]) ||
                   ((size_in == MEM_WORD) && (alu_result[1:0] != 2'b00)));
`else
  assign mis_in = 1'b0;
`endif

  // Store data replicated across lanes plus the byte enables for the addressed lanes.
  always_comb begin
    wdata_d = store_data;
    be_d    = BE_WORD;
    case (size_in)
      MEM_BYTE: begin
        wdata_d = {4{store_data[7:0]}};
        be_d    = 4'b0001 << alu_result[1:0];
      end
      MEM_HALF: begin
        wdata_d = {2{store_data[15:0]}};
        be_d    = alu_result[1] ? BE_HI_HALF : BE_LO_HALF;
      end
      default: ;
    endcase
  end

  load_align u_load_align (
    .rdata       (rdata_q),
    .addr        (addr_q[1:0]),
    .size        (size_q),
    .is_unsigned (uns_q),
    .data        (ld_data)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and stage outputs; default is a bubble showing the latched fields.
  always_comb begin
    state_d        = state_q;
    latch          = 1'b0;
    stall          = 1'b0;
    misaligned     = 1'b0;
    reg_write_out  = 1'b0;
    mem_to_reg_out = 1'b0;
    halted_out     = 1'b0;
    alu_result_out = addr_q;
    rd_num_out     = rd_q;
    read_data      = st_q ? '0 : ld_data;
    case (state_q)
      IDLE: begin
        if (valid_in) begin
          if (mis_in) begin
            // Faulting access: no memory request, halt the pipeline at writeback.
            misaligned     = 1'b1;
            halted_out     = 1'b1;
            alu_result_out = alu_result;
            rd_num_out     = rd_num;
            read_data      = '0;
          end else if (mem_op) begin
            latch   = 1'b1;
            stall   = 1'b1;
            state_d = BUSY;
          end else begin
            reg_write_out  = reg_write;
            mem_to_reg_out = mem_to_reg;
            halted_out     = halted;
            alu_result_out = alu_result;
            rd_num_out     = rd_num;
            read_data      = '0;
          end
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (dmem_ack) state_d = DONE;
      end
      DONE: begin
        reg_write_out  = rw_q;
        mem_to_reg_out = m2r_q;
        halted_out     = halt_q;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Capture the instruction on entry to BUSY, raise the request, and take load data on ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= BE_NONE;
      size_q  <= MEM_BYTE;
      st_q    <= 1'b0;
      uns_q   <= 1'b0;
      m2r_q   <= 1'b0;
      rw_q    <= 1'b0;
      halt_q  <= 1'b0;
      rd_q    <= '0;
      rdata_q <= '0;
    end else if (latch) begin
      req_q   <= 1'b1;
      addr_q  <= alu_result;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      size_q  <= size_in;
      st_q    <= mem_write;
      uns_q   <= mem_unsigned;
      m2r_q   <= mem_to_reg;
      rw_q    <= reg_write;
      halt_q  <= halted;
      rd_q    <= rd_num;
    end else if ((state_q == BUSY) && dmem_ack) begin
      req_q   <= 1'b0;
      rdata_q <= dmem_rdata;
    end
  end

  assign dmem_req   = req_q;
  assign dmem_we    = req_q & st_q;
  assign dmem_be    = req_q ? be_q : BE_NONE;
  assign dmem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign dmem_wdata = wdata_q;

endmodule
